// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Two-requester UART transmitter (8N1, LSB first, idle high). A round-robin
// arbiter picks one requester per frame while the line is idle; a requester
// that sets its lock bit on an accepted byte keeps the line for its next byte,
// which lets it send a multi-byte message without interleaving.
//
// Parameters
//   BAUD_DIV : clock cycles per UART bit (2..65535)
//   LOCK_EN  : 1 enables per-requester line locking
//
// Ports
//   CLK                 system clock, all state changes on its rising edge
//   RESET               synchronous, active-high reset
//   req0_valid/data/lock  requester 0 byte offer and hold-line request
//   req0_ready          byte accepted from requester 0 this cycle
//   req1_valid/data/lock  requester 1 byte offer and hold-line request
//   req1_ready          byte accepted from requester 1 this cycle
//   RsTx                registered serial output
//   busy                frame in progress
//   grant_id            requester owning the current or most recent frame
// -----------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int unsigned BAUD_DIV = 5208,
  parameter logic        LOCK_EN  = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_lock,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic       RsTx,
  output logic       busy,
  output logic       grant_id
);

  localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state_reg,    state_next;
  logic [15:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]  bit_cnt_reg,  bit_cnt_next;
  logic [7:0]  shift_reg,    shift_next;
  logic        tx_reg,       tx_next;
  logic        grant_id_reg, grant_id_next;
  logic        prio_reg,     prio_next;   // requester that wins a tie
  logic        lock_reg,     lock_next;   // grant_id_reg owns the line

  // Requester inputs gathered into vectors so the arbiter can index them.
  logic       valid_vec [2];
  logic [7:0] data_vec  [2];
  logic       lock_vec  [2];
  logic       ready_vec [2];

  assign valid_vec[0] = req0_valid;
  assign valid_vec[1] = req1_valid;
  assign data_vec[0]  = req0_data;
  assign data_vec[1]  = req1_data;
  assign lock_vec[0]  = req0_lock;
  assign lock_vec[1]  = req1_lock;

  // ---------------------------------------------------------------------------
  // Arbiter (combinational)
  // ---------------------------------------------------------------------------
  logic owner_valid;
  logic lock_hold;
  logic grant_any;
  logic grant_sel;
  logic idle_open;

  assign owner_valid = valid_vec[grant_id_reg];
  // A lock only binds while its owner keeps offering; once the owner goes
  // quiet in an idle cycle the line opens to normal round-robin at once.
  assign lock_hold   = LOCK_EN && lock_reg && owner_valid;
  assign idle_open   = (state_reg == IDLE) && !RESET;

  always_comb begin
    grant_any = 1'b0;
    grant_sel = 1'b0;
    if (lock_hold) begin
      grant_any = 1'b1;
      grant_sel = grant_id_reg;
    end else if (req0_valid && req1_valid) begin
      grant_any = 1'b1;
      grant_sel = prio_reg;
    end else if (req0_valid) begin
      grant_any = 1'b1;
      grant_sel = 1'b0;
    end else if (req1_valid) begin
      grant_any = 1'b1;
      grant_sel = 1'b1;
    end
  end

  // Ready is a pure function of state and valids; only one can be high.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign ready_vec[gi] = idle_open && grant_any && (grant_sel == 1'(gi));
  end

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  // ---------------------------------------------------------------------------
  // Frame sequencer: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    grant_id_next = grant_id_reg;
    prio_next     = prio_reg;
    lock_next     = lock_reg;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (grant_any) begin
          shift_next    = data_vec[grant_sel];
          grant_id_next = grant_sel;
          prio_next     = ~grant_sel;
          lock_next     = LOCK_EN && lock_vec[grant_sel];
          baud_cnt_next = BAUD_LOAD;
          bit_cnt_next  = 3'd0;
          tx_next       = 1'b0;          // start bit appears next cycle
          state_next    = START;
        end else if (lock_reg && !owner_valid) begin
          lock_next = 1'b0;
        end
      end

      START: begin
        if (baud_cnt_reg == 16'd0) begin
          baud_cnt_next = BAUD_LOAD;
          bit_cnt_next  = 3'd0;
          tx_next       = shift_reg[0];
          shift_next    = {1'b0, shift_reg[7:1]};
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end

      DATA: begin
        if (baud_cnt_reg == 16'd0) begin
          baud_cnt_next = BAUD_LOAD;
          if (bit_cnt_reg == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            tx_next      = shift_reg[0];
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (baud_cnt_reg == 16'd0) begin
          state_next = IDLE;
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= 16'd0;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      tx_reg       <= 1'b1;
      grant_id_reg <= 1'b0;
      prio_reg     <= 1'b0;
      lock_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      grant_id_reg <= grant_id_next;
      prio_reg     <= prio_next;
      lock_reg     <= lock_next;
    end
  end

  assign RsTx     = tx_reg;
  assign busy     = (state_reg != IDLE);
  assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Directed bench for uart_tx_sched at BAUD_DIV=4. A frame-level model (frame
// timer, expected-byte queue, arbitration rules) predicts every output on
// every cycle; a UART monitor decodes the line independently, and each test
// pins the results with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int B     = 4;
  localparam int FRAME = 10 * B;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       req0_valid = 1'b0, req0_lock = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_lock = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req0_ready, req1_ready, RsTx, busy, grant_id;

  always #5 clk = ~clk;

  uart_tx_sched #(.BAUD_DIV(B), .LOCK_EN(1'b1)) dut (
    .CLK        (clk),
    .RESET      (RESET),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_lock  (req0_lock),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_lock  (req1_lock),
    .req1_ready (req1_ready),
    .RsTx       (RsTx),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- model state ----------------
  bit         m_init = 0;
  int         m_cnt  = 0;      // cycles of frame still to run, 0 = idle
  logic [7:0] m_data = 8'h00;
  logic       m_gid  = 1'b0;
  logic       m_prio = 1'b0;
  logic       m_lock = 1'b0;
  logic [7:0] exp_q[$];

  // ---------------- monitor / logs ----------------
  bit         mon_act = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] dec_log[$];
  int         start_log[$];
  logic       gid_log[$];
  logic       acc_log[$];
  int         cyc = 0;
  int         busy_cnt = 0, rdy0_cnt = 0, rdy1_cnt = 0;

  logic exp_tx, exp_busy, exp_r0, exp_r1, pick_ok, pick;
  int   e_idx, b_idx;

  always @(negedge clk) begin
    cyc++;
    if (m_init) begin
      // Expected line level from elapsed time within the frame.
      exp_busy = (m_cnt != 0);
      if (m_cnt == 0) exp_tx = 1'b1;
      else begin
        e_idx = FRAME - m_cnt;
        b_idx = e_idx / B;
        if (b_idx == 0)      exp_tx = 1'b0;
        else if (b_idx == 9) exp_tx = 1'b1;
        else                 exp_tx = m_data[b_idx-1];
      end
      // Who may be granted this cycle.
      pick_ok = 1'b0;
      pick    = 1'b0;
      if (m_cnt == 0 && !RESET) begin
        if (m_lock && (m_gid ? req1_valid : req0_valid)) begin pick_ok = 1'b1; pick = m_gid; end
        else if (req0_valid && req1_valid) begin pick_ok = 1'b1; pick = m_prio; end
        else if (req0_valid) begin pick_ok = 1'b1; pick = 1'b0; end
        else if (req1_valid) begin pick_ok = 1'b1; pick = 1'b1; end
      end
      exp_r0 = pick_ok && !pick;
      exp_r1 = pick_ok && pick;

      check("rstx", 32'(RsTx), 32'(exp_tx));
      check("busy", 32'(busy), 32'(exp_busy));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("req0_ready", 32'(req0_ready), 32'(exp_r0));
      check("req1_ready", 32'(req1_ready), 32'(exp_r1));

      if (busy === 1'b1) busy_cnt++;
      if (req0_ready === 1'b1) begin rdy0_cnt++; acc_log.push_back(1'b0); end
      if (req1_ready === 1'b1) begin rdy1_cnt++; acc_log.push_back(1'b1); end

      // UART monitor: samples each bit in its middle.
      if (RESET) mon_act = 0;
      else begin
        if (!mon_act && RsTx === 1'b0) begin
          mon_act = 1;
          mon_cnt = 0;
          start_log.push_back(cyc);
          gid_log.push_back(grant_id);
        end
        if (mon_act) begin
          if (mon_cnt == B/2) check("start_bit", 32'(RsTx), 32'd0);
          else if (mon_cnt == 9*B + B/2) check("stop_bit", 32'(RsTx), 32'd1);
          else for (int k = 1; k <= 8; k++) if (mon_cnt == k*B + B/2) mon_byte[k-1] = RsTx;
          if (mon_cnt == FRAME - 1) begin
            mon_act = 0;
            dec_log.push_back(mon_byte);
            if (exp_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL frame_byte: got unexpected frame %0h, required none", mon_byte);
            end else check("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
          end else mon_cnt++;
        end
      end

      // Advance model across the coming rising edge.
      if (RESET) begin
        m_cnt = 0; m_gid = 1'b0; m_prio = 1'b0; m_lock = 1'b0;
        exp_q.delete();
      end else if (m_cnt > 0) m_cnt--;
      else if (pick_ok) begin
        m_cnt  = FRAME;
        m_data = pick ? req1_data : req0_data;
        m_gid  = pick;
        m_prio = !pick;
        m_lock = pick ? req1_lock : req0_lock;
        exp_q.push_back(m_data);
      end else if (m_lock && !(m_gid ? req1_valid : req0_valid)) m_lock = 1'b0;
    end else if (RESET) begin
      m_init = 1; m_cnt = 0; m_gid = 1'b0; m_prio = 1'b0; m_lock = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] qb(input int i);
    if (i < dec_log.size()) return 32'(dec_log[i]);
    return 'x;
  endfunction
  function automatic logic [31:0] qa(input int i);
    if (i < acc_log.size()) return 32'(acc_log[i]);
    return 'x;
  endfunction
  function automatic logic [31:0] qg(input int i);
    if (i < gid_log.size()) return 32'(gid_log[i]);
    return 'x;
  endfunction
  function automatic logic [31:0] qs(input int i);
    if (i + 1 < start_log.size()) return 32'(start_log[i+1] - start_log[i]);
    return 'x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    repeat (n) tick();
    RESET = 1'b0;
  endtask

  task automatic clear_logs();
    dec_log.delete(); start_log.delete(); gid_log.delete(); acc_log.delete();
    busy_cnt = 0; rdy0_cnt = 0; rdy1_cnt = 0;
  endtask

  // Returns at negedge+1 of the cycle in which the accept count reached n.
  task automatic wait_acc(input int n, input string name);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      #1;
      if (acc_log.size() >= n) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s: accepts seen %0d, required %0d within 300 cycles", name, acc_log.size(), n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);
    @(negedge clk); #1;
    check("rst_rstx", 32'(RsTx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    tick();

    // Single byte 0x41 from requester 0.
    clear_logs();
    req0_data = 8'h41; req0_lock = 1'b0; req0_valid = 1'b1;
    wait_acc(1, "t028_accept");
    tick(); req0_valid = 1'b0;
    repeat (FRAME + 5) tick();
    check("t028_ready_cycles", 32'(rdy0_cnt), 32'd1);
    check("t028_busy_cycles", 32'(busy_cnt), 32'd40);
    check("t028_byte", qb(0), 32'h41);
    check("t028_frames", 32'(dec_log.size()), 32'd1);

    // Both requesters held valid: alternate grants 0,1,0,1.
    do_reset(2);
    clear_logs();
    req0_data = 8'h55; req1_data = 8'hAA; req0_lock = 1'b0; req1_lock = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(4, "t029_accepts");
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (FRAME + 5) tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t029_grant%0d", i), qa(i), 32'(i % 2));
      check($sformatf("t029_gid%0d", i), qg(i), 32'(i % 2));
      check($sformatf("t029_byte%0d", i), qb(i), (i % 2) ? 32'hAA : 32'h55);
    end
    for (int i = 0; i < 3; i++) check($sformatf("t029_period%0d", i), qs(i), 32'd41);

    // Locked two-byte message from requester 1 while requester 0 waits.
    clear_logs();
    req1_data = 8'h48; req1_lock = 1'b1; req1_valid = 1'b1;
    wait_acc(1, "t030_first");
    tick();
    req1_data = 8'h49; req1_lock = 1'b0;
    req0_data = 8'h30; req0_lock = 1'b0; req0_valid = 1'b1;
    wait_acc(2, "t030_second");
    tick(); req1_valid = 1'b0;
    wait_acc(3, "t030_third");
    tick(); req0_valid = 1'b0;
    repeat (FRAME + 5) tick();
    check("t030_grant0", qa(0), 32'd1);
    check("t030_grant1", qa(1), 32'd1);
    check("t030_grant2", qa(2), 32'd0);
    check("t030_byte0", qb(0), 32'h48);
    check("t030_byte1", qb(1), 32'h49);
    check("t030_byte2", qb(2), 32'h30);

    // Reset during data bit 3 of 0xFF, then a fresh request.
    do_reset(1);
    clear_logs();
    req0_data = 8'hFF; req0_lock = 1'b0; req0_valid = 1'b1;
    wait_acc(1, "t031_accept");
    tick(); req0_valid = 1'b0;
    repeat (17) tick();
    check("t031_in_bit3", 32'(busy), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    @(negedge clk); #1;
    check("t031_rstx_after_reset", 32'(RsTx), 32'd1);
    check("t031_busy_after_reset", 32'(busy), 32'd0);
    tick();
    req0_data = 8'h12; req0_valid = 1'b1;
    wait_acc(2, "t031_reaccept");
    tick(); req0_valid = 1'b0;
    repeat (FRAME + 5) tick();
    check("t031_frames", 32'(dec_log.size()), 32'd1);
    check("t031_byte", qb(0), 32'h12);

    // Requester 0 pulses valid only while the line is busy.
    clear_logs();
    req1_data = 8'h77; req1_lock = 1'b0; req1_valid = 1'b1;
    wait_acc(1, "t032_accept");
    tick(); req1_valid = 1'b0;
    repeat (5) tick();
    req0_data = 8'h66; req0_valid = 1'b1;
    repeat (10) tick();
    req0_valid = 1'b0;
    repeat (FRAME + 5) tick();
    check("t032_ready0", 32'(rdy0_cnt), 32'd0);
    check("t032_frames", 32'(dec_log.size()), 32'd1);
    check("t032_byte", qb(0), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001: Parameter BAUD_DIV, default 5208, CLK cycles per UART bit (100 MHz / 19200 baud); legal range 2..65535.
REQ-002: Parameter LOCK_EN, default 1, enables per-requester line locking for multi-byte messages.
REQ-003: CLK  input  1  system clock; all state changes on rising edge.
REQ-004: RESET  input  1  synchronous, active-high reset.
REQ-005: req0_valid  input  1  requester 0 has a byte to send.
REQ-006: req0_data  input  8  requester 0 byte; sampled on accept.
REQ-007: req0_lock  input  1  requester 0 holds the line after its current byte.
REQ-008: req0_ready  output  1  byte accepted from requester 0 this cycle.
REQ-009: req1_valid, req1_data, req1_lock, req1_ready  as REQ-005..008, for requester 1.
REQ-010: RsTx  output  1  serial line, 8N1, LSB first, idle high.
REQ-011: busy  output  1  frame in progress (state != IDLE).
REQ-012: grant_id  output  1  requester owning the current or most recent frame.

Function
REQ-013: FSM states: IDLE, START, DATA, STOP.
REQ-014: In IDLE, reqN_ready = reqN_valid AND (arbiter selects N); combinational, never depends on RsTx; at most one ready high per cycle.
REQ-015: Accept = reqN_valid AND reqN_ready; on accept, latch data into an 8-bit shift register, set grant_id=N, go to START.
REQ-016: Arbitration: round-robin; the requester not served last wins when both are valid; after reset requester 0 has priority.
REQ-017: Lock: if LOCK_EN=1 and the last-accepted requester's lock was 1 at accept, only that requester may be granted until it is accepted with lock=0 or is not valid in an IDLE cycle; the other waits.
REQ-018: Baud counter: 16-bit, loads BAUD_DIV-1 on entering each bit state, decrements each cycle, bit ends at 0.
REQ-019: START drives RsTx=0 for BAUD_DIV cycles, beginning the cycle after accept.
REQ-020: DATA drives bits 0..7 LSB first, BAUD_DIV cycles each; a 3-bit bit counter advances at each bit end; exit after bit 7.
REQ-021: STOP drives RsTx=1 for BAUD_DIV cycles, then IDLE.
REQ-022: RsTx is registered and glitch-free; 1 in IDLE and STOP.
REQ-023: Frame = 10*BAUD_DIV cycles; IDLE lasts at least 1 cycle between frames; back-to-back period 10*BAUD_DIV+1 cycles.
REQ-024: Valid deasserted or data changed after accept has no effect on the frame in flight.
REQ-025: Valid dropped before accept withdraws the request; no byte is sent and no state changes.

Reset
REQ-026: RESET=1 at any edge, including mid-frame, forces IDLE, RsTx=1, busy=0, grant_id=0, req0_ready=req1_ready=0, counters=0, lock released, priority to requester 0; the partial frame is abandoned.
REQ-027: Outputs hold reset values in the first cycle after RESET deasserts unless a valid request is present.

Verification (BAUD_DIV=4)
REQ-028: req0 sends 0x41, lock=0 -> req0_ready one cycle; RsTx low 4 cycles, then 1,0,0,0,0,0,1,0 at 4 cycles each, high 4 cycles; busy high 40 cycles.
REQ-029: Both valid, 0x55 and 0xAA held, locks=0 -> grants alternate 0,1,0,1; frames start 41 cycles apart; grant_id matches each frame.
REQ-030: req1 streams 0x48,0x49 with lock=1,0 while req0 is valid -> both req1 bytes sent consecutively; req0 granted third.
REQ-031: RESET pulsed during DATA bit 3 of 0xFF -> next cycle RsTx=1, busy=0; no stop bit; a subsequent request from requester 0 is accepted.
REQ-032: req0_valid pulsed during a busy frame and dropped before IDLE -> req0_ready never asserts; no extra frame.
REQ-033: Bench UART monitor decodes every frame at BAUD_DIV and checks the byte sequence and 8N1 framing (start=0, stop=1).
